// File: rtl/rfx_vumeter_axil_slave.sv
// rfx_vumeter AXI4-Lite responder: four read/write control registers plus a
// peak-magnitude meter and a valid-sample counter, both exposed read-only.
module rfx_vumeter_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int SAMPLE_WIDTH       = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            sample_valid,
   input  logic [SAMPLE_WIDTH-1:0]         sample_data,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg3
);

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

   w_state_e                        w_state_q, w_state_d;
   r_state_e                        r_state_q, r_state_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_q [4];
   logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_d [4];
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [SAMPLE_WIDTH-1:0]         peak_q, peak_d;
   logic [31:0]                     count_q, count_d;

   logic [2:0]                      wr_word;
   logic [2:0]                      rd_word;
   logic                            wr_fire;
   logic                            rd_fire;
   logic                            meter_clear;
   logic [SAMPLE_WIDTH-1:0]         sample_mag;
   logic                            unused_bits;

   assign wr_word     = S_AXI_AWADDR[4:2];
   assign rd_word     = S_AXI_ARADDR[4:2];
   assign wr_fire     = (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_fire     = (r_state_q == R_IDLE) && S_AXI_ARVALID;
   assign meter_clear = wr_fire && (wr_word == 3'd4);
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = wr_fire;
   assign S_AXI_WREADY  = wr_fire;
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = rd_fire;
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RDATA   = rdata_q;

   assign ctrl_reg0 = ctrl_q[0];
   assign ctrl_reg1 = ctrl_q[1];
   assign ctrl_reg2 = ctrl_q[2];
   assign ctrl_reg3 = ctrl_q[3];

   // Write channel: both AW and W must be present together; response held until BREADY.
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (wr_fire)      w_state_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Control register update, byte-lane masked, in the handshake cycle.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ctrl_d[i] = ctrl_q[i];
         if (wr_fire && (wr_word == 3'(i))) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (S_AXI_WSTRB[b]) begin
                  ctrl_d[i][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
               end
            end
         end
      end
   end

   // Read channel: capture addressed word at the AR handshake, hold until RREADY.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (rd_fire) begin
               r_state_d = R_DATA;
               case (rd_word)
                  3'd0, 3'd1, 3'd2, 3'd3: rdata_d = ctrl_q[rd_word[1:0]];
                  3'd4:    rdata_d = {{(C_S_AXI_DATA_WIDTH-SAMPLE_WIDTH){1'b0}}, peak_q};
                  3'd5:    rdata_d = count_q;
                  default: rdata_d = '0;
               endcase
            end
         end
         R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Meter: absolute value of the sample; the most negative code maps to 0x8000.
   always_comb begin
      sample_mag = sample_data;
      if (sample_data[SAMPLE_WIDTH-1]) begin
         sample_mag = ~sample_data + {{(SAMPLE_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Peak hold and saturating counter; a PEAK-register write clears both and drops the sample.
   always_comb begin
      peak_d  = peak_q;
      count_d = count_q;
      if (meter_clear) begin
         peak_d  = '0;
         count_d = '0;
      end else if (sample_valid) begin
         if (sample_mag > peak_q) begin
            peak_d = sample_mag;
         end
         if (count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
         end
      end
   end

   // State and register flops; reset aborts any transaction in flight.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         peak_q    <= '0;
         count_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            ctrl_q[i] <= '0;
         end
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         peak_q    <= peak_d;
         count_q   <= count_d;
         for (int i = 0; i < 4; i++) begin
            ctrl_q[i] <= ctrl_d[i];
         end
      end
   end

endmodule

// File: tb/tb_rfx_vumeter_axil_slave.sv
// Self-checking bench for rfx_vumeter_axil_slave: register map, byte strobes,
// meter peak/count, clear-vs-sample priority, channel handshake timing and reset.
module tb_rfx_vumeter_axil_slave;

   logic        clock;
   logic        reset;
   logic [4:0]  awAddr;
   logic [2:0]  awProt;
   logic        awValid;
   logic        awReady;
   logic [31:0] wData;
   logic [3:0]  wStrb;
   logic        wValid;
   logic        wReady;
   logic [1:0]  bResp;
   logic        bValid;
   logic        bReady;
   logic [4:0]  arAddr;
   logic [2:0]  arProt;
   logic        arValid;
   logic        arReady;
   logic [31:0] rData;
   logic [1:0]  rResp;
   logic        rValid;
   logic        rReady;
   logic        sampleValid;
   logic [15:0] sampleData;
   logic [31:0] ctrlReg0, ctrlReg1, ctrlReg2, ctrlReg3;

   int          total;
   int          bad;
   logic [31:0] expQ [$];
   logic [31:0] regModel [4];
   logic [15:0] peakModel;
   logic [31:0] countModel;

   rfx_vumeter_axil_slave dut (
      .S_AXI_ACLK    (clock),
      .S_AXI_ARESET  (reset),
      .S_AXI_AWADDR  (awAddr),
      .S_AXI_AWPROT  (awProt),
      .S_AXI_AWVALID (awValid),
      .S_AXI_AWREADY (awReady),
      .S_AXI_WDATA   (wData),
      .S_AXI_WSTRB   (wStrb),
      .S_AXI_WVALID  (wValid),
      .S_AXI_WREADY  (wReady),
      .S_AXI_BRESP   (bResp),
      .S_AXI_BVALID  (bValid),
      .S_AXI_BREADY  (bReady),
      .S_AXI_ARADDR  (arAddr),
      .S_AXI_ARPROT  (arProt),
      .S_AXI_ARVALID (arValid),
      .S_AXI_ARREADY (arReady),
      .S_AXI_RDATA   (rData),
      .S_AXI_RRESP   (rResp),
      .S_AXI_RVALID  (rValid),
      .S_AXI_RREADY  (rReady),
      .sample_valid  (sampleValid),
      .sample_data   (sampleData),
      .ctrl_reg0     (ctrlReg0),
      .ctrl_reg1     (ctrlReg1),
      .ctrl_reg2     (ctrlReg2),
      .ctrl_reg3     (ctrlReg3)
   );

   // Free-running 100 MHz clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Absolute value of a 16-bit two's-complement sample.
   function automatic logic [15:0] magOf(input logic [15:0] s);
      return s[15] ? (16'h0000 - s) : s;
   endfunction

   // Drive one valid sample for one clock and advance the meter model.
   task automatic applyStimulus(input logic [15:0] s);
      @(negedge clock);
      sampleValid = 1'b1;
      sampleData  = s;
      if (magOf(s) > peakModel) peakModel = magOf(s);
      if (countModel != 32'hFFFF_FFFF) countModel++;
      @(negedge clock);
      sampleValid = 1'b0;
   endtask

   // Full write transaction with both channels presented together.
   task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int n;
      @(negedge clock);
      awAddr = addr; wData = data; wStrb = strb;
      awValid = 1'b1; wValid = 1'b1;
      #1;
      n = 0;
      while (!(awReady && wReady) && n < 20) begin @(negedge clock); #1; n++; end
      checkOutput("wr_ready", {30'b0, awReady, wReady}, 32'h3);
      if (addr[4:2] < 3'd4) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) regModel[addr[3:2]][8*b +: 8] = data[8*b +: 8];
      end else if (addr[4:2] == 3'd4) begin
         peakModel  = '0;
         countModel = '0;
      end
      @(posedge clock);
      @(negedge clock);
      awValid = 1'b0; wValid = 1'b0; bReady = 1'b1;
      #1;
      n = 0;
      while (!bValid && n < 20) begin @(negedge clock); #1; n++; end
      checkOutput("wr_bvalid", {31'b0, bValid}, 32'h1);
      checkOutput("wr_bresp", {30'b0, bResp}, 32'h0);
      @(posedge clock);
      @(negedge clock);
      bReady = 1'b0;
   endtask

   // Full read transaction; expectation goes through the scoreboard queue.
   task automatic axiRead(input logic [4:0] addr, input logic [31:0] expected, input string tag);
      int n;
      expQ.push_back(expected);
      @(negedge clock);
      arAddr = addr; arValid = 1'b1;
      #1;
      n = 0;
      while (!arReady && n < 20) begin @(negedge clock); #1; n++; end
      checkOutput({tag, "_arready"}, {31'b0, arReady}, 32'h1);
      @(posedge clock);
      @(negedge clock);
      arValid = 1'b0; rReady = 1'b1;
      #1;
      n = 0;
      while (!rValid && n < 20) begin @(negedge clock); #1; n++; end
      checkOutput({tag, "_rvalid"}, {31'b0, rValid}, 32'h1);
      checkOutput(tag, rData, expQ.pop_front());
      checkOutput({tag, "_rresp"}, {30'b0, rResp}, 32'h0);
      @(posedge clock);
      @(negedge clock);
      rReady = 1'b0;
   endtask

   // Main sequence.
   initial begin
      logic [31:0] t1Data [4];
      logic [15:0] t3Samples [5];
      total = 0; bad = 0;
      t1Data    = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
      t3Samples = '{16'd100, 16'hF830, 16'd1500, 16'h8000, 16'd5};
      for (int i = 0; i < 4; i++) regModel[i] = '0;
      peakModel = '0; countModel = '0;
      reset = 1'b1;
      awAddr = '0; awProt = '0; awValid = 1'b0; wData = '0; wStrb = '0; wValid = 1'b0;
      bReady = 1'b0; arAddr = '0; arProt = '0; arValid = 1'b0; rReady = 1'b0;
      sampleValid = 1'b0; sampleData = '0;

      repeat (3) @(negedge clock);
      checkOutput("rst_bvalid", {31'b0, bValid}, 32'h0);
      checkOutput("rst_rvalid", {31'b0, rValid}, 32'h0);
      checkOutput("rst_rdata", rData, 32'h0);
      checkOutput("rst_ctrl0", ctrlReg0, 32'h0);
      reset = 1'b0;

      $display("[TB] register write/readback");
      for (int i = 0; i < 4; i++) axiWrite(5'(i * 4), t1Data[i], 4'hF);
      for (int i = 0; i < 4; i++) axiRead(5'(i * 4), t1Data[i], "reg_rb");
      checkOutput("ctrl_reg0", ctrlReg0, 32'h0101FFFF);
      checkOutput("ctrl_reg1", ctrlReg1, 32'hABCD0001);
      checkOutput("ctrl_reg2", ctrlReg2, 32'hDEAD0011);
      checkOutput("ctrl_reg3", ctrlReg3, 32'hBEEF0011);

      $display("[TB] byte strobes");
      axiWrite(5'h04, 32'h0, 4'hF);
      axiWrite(5'h04, 32'hFFFFFFFF, 4'b0101);
      axiRead(5'h04, 32'h00FF00FF, "strb_rb");
      checkOutput("strb_model", regModel[1], 32'h00FF00FF);

      $display("[TB] meter");
      for (int i = 0; i < 5; i++) applyStimulus(t3Samples[i]);
      axiRead(5'h10, {16'h0, peakModel}, "peak");
      axiRead(5'h14, countModel, "count");
      checkOutput("peak_model", {16'h0, peakModel}, 32'h00008000);

      $display("[TB] clear with simultaneous sample");
      @(negedge clock);
      awAddr = 5'h10; wData = 32'h12345678; wStrb = 4'hF;
      awValid = 1'b1; wValid = 1'b1;
      sampleValid = 1'b1; sampleData = 16'd7;
      #1;
      checkOutput("clr_awready", {31'b0, awReady}, 32'h1);
      @(posedge clock);
      @(negedge clock);
      awValid = 1'b0; wValid = 1'b0; sampleValid = 1'b0; bReady = 1'b1;
      peakModel = '0; countModel = '0;
      #1;
      checkOutput("clr_bvalid", {31'b0, bValid}, 32'h1);
      @(posedge clock);
      @(negedge clock);
      bReady = 1'b0;
      axiRead(5'h10, 32'h0, "clr_peak");
      axiRead(5'h14, 32'h0, "clr_count");
      applyStimulus(16'd7);
      axiRead(5'h10, {16'h0, peakModel}, "post_peak");
      axiRead(5'h14, countModel, "post_count");

      $display("[TB] delayed W channel and held response");
      @(negedge clock);
      awAddr = 5'h08; wData = 32'hCAFEF00D; wStrb = 4'hF;
      awValid = 1'b1; wValid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput("t5_early_ready", {30'b0, awReady, wReady}, 32'h0);
         @(negedge clock);
      end
      wValid = 1'b1;
      #1;
      checkOutput("t5_ready", {30'b0, awReady, wReady}, 32'h3);
      regModel[2] = 32'hCAFEF00D;
      @(posedge clock);
      @(negedge clock);
      awValid = 1'b0; wValid = 1'b0; bReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("t5_bvalid_held", {31'b0, bValid}, 32'h1);
         @(negedge clock);
      end
      bReady = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bReady = 1'b0;
      #1;
      checkOutput("t5_bvalid_drop", {31'b0, bValid}, 32'h0);
      @(negedge clock);
      #1;
      checkOutput("t5_single_resp", {31'b0, bValid}, 32'h0);
      axiRead(5'h08, regModel[2], "t5_rb");

      $display("[TB] unmapped words");
      axiWrite(5'h18, 32'h12345678, 4'hF);
      axiRead(5'h18, 32'h0, "unmapped_18");
      axiRead(5'h14, countModel, "count_after_18");

      $display("[TB] same-cycle read and write of REG0");
      @(negedge clock);
      arAddr = 5'h00; arValid = 1'b1;
      awAddr = 5'h00; wData = 32'h55AA55AA; wStrb = 4'hF;
      awValid = 1'b1; wValid = 1'b1;
      #1;
      checkOutput("rw_ready", {29'b0, arReady, awReady, wReady}, 32'h7);
      expQ.push_back(regModel[0]);
      @(posedge clock);
      @(negedge clock);
      arValid = 1'b0; awValid = 1'b0; wValid = 1'b0; rReady = 1'b1; bReady = 1'b1;
      regModel[0] = 32'h55AA55AA;
      #1;
      checkOutput("rw_valids", {30'b0, rValid, bValid}, 32'h3);
      checkOutput("rw_old_data", rData, expQ.pop_front());
      @(posedge clock);
      @(negedge clock);
      rReady = 1'b0; bReady = 1'b0;
      axiRead(5'h00, regModel[0], "rw_new_data");

      $display("[TB] reset during read response");
      @(negedge clock);
      arAddr = 5'h00; arValid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      arValid = 1'b0;
      #1;
      checkOutput("mid_rvalid", {31'b0, rValid}, 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_rvalid", {31'b0, rValid}, 32'h0);
      checkOutput("mid_rst_rdata", rData, 32'h0);
      checkOutput("mid_rst_ctrl0", ctrlReg0, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      regModel[0] = '0;
      axiRead(5'h00, 32'h0, "after_rst");

      checkOutput("sb_empty", expQ.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
